map_table: RTL and testbench
============================

# map_table

Register-rename map table (RAT) sitting directly downstream of the speculative free list. It accepts up to `N` decoded instructions per cycle, pops one free PRN per destination-writing instruction, and emits renamed source/destination PRNs plus the displaced old PRN for the ROB. It resolves intra-group dependencies. On squash it restores the whole mapping from the retirement map, in the same cycle the free list restores.

## Interface
Parameters:
- `ARCH_SZ`, default `` `REG_SZ `` (32): number of architectural registers.
- `PHYS_SZ`, default `` `PHYS_REG_SZ_R10K ``: number of physical registers; sets the PRN range.

Ports:
- `clock`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high.
- `in_packet`  in  `[N-1:0] RENAME_REQ_PACKET`  per slot: valid, dest ARN, src1 ARN, src2 ARN; dest ARN 0 = no destination.
- `in_ready`  out  1  whole-group accept.
- `free_cnt`  in  `` `FREE_LIST_CTR_WIDTH ``  free-list occupancy (its counter).
- `pop_en`  out  `[N-1:0]`  free-list pop request.
- `pop_packet`  in  `[N-1:0] FREE_LIST_PACKET`  popped PRNs; arrives one cycle after `pop_en`.
- `out_packet`  out  `[N-1:0] RENAME_PACKET`  per slot: valid, dest PRN, old PRN, src1 PRN, src2 PRN.
- `out_ready`  in  1  dispatch accepts the whole output group.
- `squash`  in  1  restore mapping and flush.
- `rrat_map`  in  `[ARCH_SZ-1:0] PRN`  committed mapping used on squash.

## Operation
- State:
  - `table[ARCH_SZ]` of PRN.
  - S1 register: request group, captured PRNs, per-slot `prn_got`, `s1_valid`.
  - OUT register: `out_packet`.
- Accept:
  - `in_ready = !squash && free_cnt >= N && (!s1_valid || s1_adv)`.
  - On accept, `pop_en[i] = in_packet[i].valid && dest != 0`, and the group is registered into S1.
  - With no accept, `pop_en = 0`.
- Capture: in the cycle after the pop, each `pop_packet[i].valid` is latched into S1's PRN slot `i`. A slot with a destination and without a captured PRN cannot advance.
- Advance: `s1_adv = s1_valid && all needed PRNs captured (or valid this cycle) && (!out_valid_any || out_ready)`.
- Rename, evaluated combinationally at advance, for each valid slot `i` in order 0..N-1:
  - Each source PRN comes from the youngest earlier slot `j < i` with a matching nonzero dest. Otherwise it comes from `table[src]`.
  - `old_prn` uses the same forwarding rule on the dest ARN.
  - Source ARN 0 always reads PRN 0.
- Table write at advance: for each slot with a destination, `table[dest] <= new PRN`. When several slots share a dest, the highest slot wins.
- Output:
  - OUT loads on `s1_adv`.
  - OUT clears when `out_ready` is high and nothing new advances.
  - OUT holds while `out_ready` is low.
- Squash, highest priority:
  - `table <= rrat_map`; S1 and OUT valids cleared.
  - Captured and in-flight PRNs are discarded; the free list restores itself on the same edge.
  - `pop_en = 0` and `in_ready = 0` during squash.
- Reset:
  - `table[i] = i`.
  - S1 and OUT empty; all `out_packet` fields 0.
  - `in_ready` follows its equation (1 once `free_cnt >= N`).
  - `pop_en = 0`.

## Timing
- Group accepted in cycle t → PRNs arrive in t+1 → `out_packet` valid from t+2 (two-cycle latency); throughput is one group per cycle.
- The table updates on the advance edge, so a group in S1 at t+2 sees the writes of the group that advanced at t+1. No bypass from OUT is needed.
- A downstream stall holds OUT and S1 and deasserts `in_ready`. PRNs that arrive during the stall are captured, never dropped.
- Squash while `reset` is low takes effect on the next edge. Reset asserted mid-operation clears immediately (asynchronous).
- Width rule: PRN fields are `$clog2(PHYS_SZ)` bits; `free_cnt` comparison is unsigned.

## Configuration
- `MAP_TABLE_DEBUG_EN` defined: adds output `table_out [ARCH_SZ-1:0] PRN`, equal to the registered `table`.
- Undefined: the port is absent and the behaviour is otherwise identical.

## Structure
- In `sys_defs.svh`: `ARN` type, `RENAME_REQ_PACKET`, `RENAME_PACKET`; PRN and `FREE_LIST_PACKET` are already shared.
- Sub-module `rename_forward`: combinational per-slot priority match over earlier slots, instantiated once per source and for the dest (`old_prn`).

## Test plan
- Reset, then a group with slot0 dest r1 and slot1 src1 r1, `pop_packet[0].prn = 40` → at t+2, slot1 `src1_prn = 40` and slot0 `old_prn = 1`.
- Two slots both with dest r5 (PRNs 40 and 41) → `table[5] = 41`; slot1 `old_prn = 40`.
- `out_ready = 0` for 3 cycles with a group in S1 and PRNs arriving → PRNs retained, `in_ready = 0`; release → output correct PRNs once.
- `free_cnt = N-1` → `in_ready = 0` and `pop_en = 0`.
- Squash with S1 and OUT full and `rrat_map[3] = 17` → next cycle all valids 0 and `table[3] = 17`.
- Source ARN 0 with an earlier slot writing dest 0 → `src_prn = 0`; no pop for that slot.

Source files
------------

// File: rtl/map_table_pkg.sv
// Shared widths and packet types for the register-rename map table.
package map_table_pkg;

    localparam int REG_SZ              = 32;
    localparam int PHYS_REG_SZ_R10K    = 64;
    localparam int N                   = 4;
    localparam int ARN_W               = $clog2(REG_SZ);
    localparam int PRN_W               = $clog2(PHYS_REG_SZ_R10K);
    localparam int FREE_LIST_CTR_WIDTH = $clog2(PHYS_REG_SZ_R10K + 1);

    typedef logic [ARN_W-1:0] ARN;
    typedef logic [PRN_W-1:0] PRN;

    typedef struct packed {
        logic valid;
        ARN   dest;
        ARN   src1;
        ARN   src2;
    } RENAME_REQ_PACKET;

    typedef struct packed {
        logic valid;
        PRN   prn;
    } FREE_LIST_PACKET;

    typedef struct packed {
        logic valid;
        PRN   dest_prn;
        PRN   old_prn;
        PRN   src1_prn;
        PRN   src2_prn;
    } RENAME_PACKET;

    // Architectural register 0 is hardwired, so it never allocates a PRN.
    function automatic logic has_dest(input RENAME_REQ_PACKET p);
        return p.valid && (p.dest != '0);
    endfunction

endpackage

// File: rtl/map_table_rename_forward.sv
// Per-slot priority match of a query ARN against the destinations of earlier
// slots in the same group; the youngest earlier writer wins, else the table.
module map_table_rename_forward
    import map_table_pkg::*;
(
    input  ARN   [N-1:0] i_query,
    input  PRN   [N-1:0] i_table_prn,
    input  ARN   [N-2:0] i_cand_dest,
    input  logic [N-2:0] i_cand_en,
    input  PRN   [N-2:0] i_cand_prn,
    output PRN   [N-1:0] o_prn
);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slot
            PRN w_sel;

            always_comb begin
                w_sel = (i_query[gi] == '0) ? '0 : i_table_prn[gi];
                for (int j = 0; j < gi; j++) begin
                    if (i_cand_en[j] && (i_cand_dest[j] == i_query[gi])) begin
                        w_sel = i_cand_prn[j];
                    end
                end
            end

            assign o_prn[gi] = w_sel;
        end
    endgenerate

endmodule

// File: rtl/map_table.sv
// Register-rename map table: two-stage pipeline (S1 waits for popped PRNs, OUT
// holds renamed group). Define MAP_TABLE_DEBUG_EN to expose the table as table_out.
module map_table
    import map_table_pkg::*;
#(
    parameter int ARCH_SZ = REG_SZ,
    parameter int PHYS_SZ = PHYS_REG_SZ_R10K
) (
    input  logic                           clock,
    input  logic                           reset,
    input  RENAME_REQ_PACKET [N-1:0]       in_packet,
    output logic                           in_ready,
    input  logic [FREE_LIST_CTR_WIDTH-1:0] free_cnt,
    output logic [N-1:0]                   pop_en,
    input  FREE_LIST_PACKET [N-1:0]        pop_packet,
    output RENAME_PACKET [N-1:0]           out_packet,
    input  logic                           out_ready,
    input  logic                           squash,
    input  PRN [ARCH_SZ-1:0]               rrat_map
`ifdef MAP_TABLE_DEBUG_EN
    ,
    output PRN [ARCH_SZ-1:0]               table_out
`endif
);

    generate
        if (PHYS_SZ > (2 ** PRN_W)) begin : g_phys_sz_exceeds_prn_width
        end
    endgenerate

    PRN               r_table [ARCH_SZ];
    logic             r_s1_valid;
    RENAME_REQ_PACKET [N-1:0] r_s1_req;
    PRN   [N-1:0]     r_s1_prn;
    logic [N-1:0]     r_s1_got;
    RENAME_PACKET [N-1:0] r_out;

    logic [N-1:0]     w_need;
    logic [N-1:0]     w_have;
    logic [N-1:0]     w_in_valid;
    logic [N-1:0]     w_out_v;
    PRN   [N-1:0]     w_new_prn;
    logic             w_s1_adv;
    logic             w_accept;

    ARN   [N-1:0]     w_q_src1;
    ARN   [N-1:0]     w_q_src2;
    ARN   [N-1:0]     w_q_dest;
    PRN   [N-1:0]     w_tab_src1;
    PRN   [N-1:0]     w_tab_src2;
    PRN   [N-1:0]     w_tab_dest;
    PRN   [N-1:0]     w_fwd_src1;
    PRN   [N-1:0]     w_fwd_src2;
    PRN   [N-1:0]     w_fwd_old;
    ARN   [N-2:0]     w_cand_dest;
    logic [N-2:0]     w_cand_en;
    PRN   [N-2:0]     w_cand_prn;
    RENAME_PACKET [N-1:0] w_renamed;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slot
            RENAME_PACKET w_slot;

            assign w_need[gi]     = has_dest(r_s1_req[gi]);
            // A PRN arriving this cycle counts as present, so S1 can advance on it.
            assign w_have[gi]     = r_s1_got[gi] | pop_packet[gi].valid;
            assign w_new_prn[gi]  = r_s1_got[gi] ? r_s1_prn[gi] : pop_packet[gi].prn;
            assign w_in_valid[gi] = in_packet[gi].valid;
            assign pop_en[gi]     = w_accept && has_dest(in_packet[gi]);
            assign w_out_v[gi]    = r_out[gi].valid;

            assign w_q_src1[gi]   = r_s1_req[gi].src1;
            assign w_q_src2[gi]   = r_s1_req[gi].src2;
            assign w_q_dest[gi]   = r_s1_req[gi].dest;
            assign w_tab_src1[gi] = r_table[r_s1_req[gi].src1];
            assign w_tab_src2[gi] = r_table[r_s1_req[gi].src2];
            assign w_tab_dest[gi] = r_table[r_s1_req[gi].dest];

            always_comb begin
                w_slot = '0;
                if (r_s1_req[gi].valid) begin
                    w_slot.valid    = 1'b1;
                    w_slot.src1_prn = w_fwd_src1[gi];
                    w_slot.src2_prn = w_fwd_src2[gi];
                    if (w_need[gi]) begin
                        w_slot.dest_prn = w_new_prn[gi];
                        w_slot.old_prn  = w_fwd_old[gi];
                    end
                end
            end

            assign w_renamed[gi] = w_slot;
        end

        for (gi = 0; gi < N - 1; gi++) begin : g_cand
            assign w_cand_dest[gi] = r_s1_req[gi].dest;
            assign w_cand_en[gi]   = w_need[gi];
            assign w_cand_prn[gi]  = w_new_prn[gi];
        end
    endgenerate

    map_table_rename_forward u_fwd_src1 (
        .i_query     (w_q_src1),
        .i_table_prn (w_tab_src1),
        .i_cand_dest (w_cand_dest),
        .i_cand_en   (w_cand_en),
        .i_cand_prn  (w_cand_prn),
        .o_prn       (w_fwd_src1)
    );

    map_table_rename_forward u_fwd_src2 (
        .i_query     (w_q_src2),
        .i_table_prn (w_tab_src2),
        .i_cand_dest (w_cand_dest),
        .i_cand_en   (w_cand_en),
        .i_cand_prn  (w_cand_prn),
        .o_prn       (w_fwd_src2)
    );

    map_table_rename_forward u_fwd_old (
        .i_query     (w_q_dest),
        .i_table_prn (w_tab_dest),
        .i_cand_dest (w_cand_dest),
        .i_cand_en   (w_cand_en),
        .i_cand_prn  (w_cand_prn),
        .o_prn       (w_fwd_old)
    );

    assign w_s1_adv = r_s1_valid && (&(~w_need | w_have)) && (!(|w_out_v) || out_ready);
    assign in_ready = !squash && (free_cnt >= FREE_LIST_CTR_WIDTH'(N)) && (!r_s1_valid || w_s1_adv);
    assign w_accept = in_ready && (|w_in_valid);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_req   <= '0;
            r_s1_prn   <= '0;
            r_s1_got   <= '0;
        end else if (squash) begin
            r_s1_valid <= 1'b0;
            r_s1_got   <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_req   <= in_packet;
            r_s1_got   <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
            r_s1_got   <= '0;
        end else if (r_s1_valid) begin
            // Stalled: keep any PRN that shows up so it is never dropped.
            for (int i = 0; i < N; i++) begin
                if (w_need[i] && !r_s1_got[i] && pop_packet[i].valid) begin
                    r_s1_got[i] <= 1'b1;
                    r_s1_prn[i] <= pop_packet[i].prn;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ARCH_SZ; i++) begin
                r_table[i] <= PRN'(i);
            end
        end else if (squash) begin
            for (int i = 0; i < ARCH_SZ; i++) begin
                r_table[i] <= rrat_map[i];
            end
        end else if (w_s1_adv) begin
            // Ascending order, so the highest slot writing a shared dest wins.
            for (int i = 0; i < N; i++) begin
                if (w_need[i]) begin
                    r_table[r_s1_req[i].dest] <= w_new_prn[i];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out <= '0;
        end else if (squash) begin
            r_out <= '0;
        end else if (w_s1_adv) begin
            r_out <= w_renamed;
        end else if (out_ready) begin
            r_out <= '0;
        end
    end

    assign out_packet = r_out;

`ifdef MAP_TABLE_DEBUG_EN
    generate
        for (gi = 0; gi < ARCH_SZ; gi++) begin : g_dbg
            assign table_out[gi] = r_table[gi];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_map_table.sv
// Directed bench for map_table: table-driven single-group vectors plus
// hand-written stall, missing-PRN, squash and asynchronous-reset sequences.
module tb_map_table;
    import map_table_pkg::*;

    logic                           clock = 1'b0;
    logic                           reset;
    RENAME_REQ_PACKET [N-1:0]       in_packet;
    logic                           in_ready;
    logic [FREE_LIST_CTR_WIDTH-1:0] free_cnt;
    logic [N-1:0]                   pop_en;
    FREE_LIST_PACKET [N-1:0]        pop_packet;
    RENAME_PACKET [N-1:0]           out_packet;
    logic                           out_ready;
    logic                           squash;
    PRN [REG_SZ-1:0]                rrat_map;

    map_table dut (
        .clock      (clock),
        .reset      (reset),
        .in_packet  (in_packet),
        .in_ready   (in_ready),
        .free_cnt   (free_cnt),
        .pop_en     (pop_en),
        .pop_packet (pop_packet),
        .out_packet (out_packet),
        .out_ready  (out_ready),
        .squash     (squash),
        .rrat_map   (rrat_map)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    FREE_LIST_PACKET [N-1:0] pending;
    PRN   next_prn;
    logic hold_prn;

    typedef struct {
        RENAME_REQ_PACKET [N-1:0] req;
        logic [N-1:0]             pop;
        PRN                       base;
        RENAME_PACKET [N-1:0]     exp;
    } vec_t;

    vec_t vecs [4];

    function automatic RENAME_REQ_PACKET mk_req(input logic v, input int d, input int s1, input int s2);
        RENAME_REQ_PACKET r;
        r.valid = v;
        r.dest  = ARN'(d);
        r.src1  = ARN'(s1);
        r.src2  = ARN'(s2);
        return r;
    endfunction

    function automatic RENAME_PACKET mk_out(input logic v, input int d, input int o, input int s1, input int s2);
        RENAME_PACKET r;
        r.valid    = v;
        r.dest_prn = PRN'(d);
        r.old_prn  = PRN'(o);
        r.src1_prn = PRN'(s1);
        r.src2_prn = PRN'(s2);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; models the free list returning popped PRNs one cycle later.
    task automatic step();
        logic [N-1:0] en;
        logic [N-1:0] dlv;
        logic         sq;
        #1;
        en = pop_en;
        sq = squash;
        for (int i = 0; i < N; i++) dlv[i] = pop_packet[i].valid;
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (sq || dlv[i]) pending[i] = '0;
            if (en[i]) begin
                pending[i].valid = 1'b1;
                pending[i].prn   = next_prn;
                next_prn         = next_prn + 1'b1;
            end
            pop_packet[i] = hold_prn ? '0 : pending[i];
        end
    endtask

    task automatic run_vec(input int k);
        in_packet = vecs[k].req;
        next_prn  = vecs[k].base;
        out_ready = 1'b1;
        #1;
        chk($sformatf("vec%0d pop_en", k), 32'(pop_en), 32'(vecs[k].pop));
        chk($sformatf("vec%0d in_ready", k), 32'(in_ready), 32'd1);
        step();
        in_packet = '0;
        step();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("vec%0d slot%0d out", k, i), 32'(out_packet[i]), 32'(vecs[k].exp[i]));
        end
        $display("vec %0d: pop_en=%b out0=%h out1=%h out2=%h out3=%h", k, vecs[k].pop,
                 out_packet[0], out_packet[1], out_packet[2], out_packet[3]);
        step();
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            vecs[k].req = '0;
            vecs[k].exp = '0;
        end
        // r1 <- 40; slot1 forwards it
        vecs[0].req[0] = mk_req(1, 1, 0, 0);
        vecs[0].req[1] = mk_req(1, 0, 1, 2);
        vecs[0].pop = 4'b0001; vecs[0].base = 6'd40;
        vecs[0].exp[0] = mk_out(1, 40, 1, 0, 0);
        vecs[0].exp[1] = mk_out(1, 0, 0, 40, 2);
        // two writers of r5, highest slot wins
        vecs[1].req[0] = mk_req(1, 5, 1, 0);
        vecs[1].req[1] = mk_req(1, 5, 5, 0);
        vecs[1].pop = 4'b0011; vecs[1].base = 6'd40;
        vecs[1].exp[0] = mk_out(1, 40, 5, 40, 0);
        vecs[1].exp[1] = mk_out(1, 41, 40, 40, 0);
        // youngest-earlier-writer priority across four slots
        vecs[2].req[0] = mk_req(1, 7, 5, 1);
        vecs[2].req[1] = mk_req(1, 7, 7, 3);
        vecs[2].req[2] = mk_req(1, 0, 7, 0);
        vecs[2].req[3] = mk_req(1, 7, 7, 2);
        vecs[2].pop = 4'b1011; vecs[2].base = 6'd10;
        vecs[2].exp[0] = mk_out(1, 10, 7, 41, 40);
        vecs[2].exp[1] = mk_out(1, 11, 10, 10, 3);
        vecs[2].exp[2] = mk_out(1, 0, 0, 11, 0);
        vecs[2].exp[3] = mk_out(1, 12, 11, 11, 2);
        // invalid slot ignored, dest 0 / src 0 handling
        vecs[3].req[0] = mk_req(0, 9, 0, 0);
        vecs[3].req[1] = mk_req(1, 0, 0, 9);
        vecs[3].req[2] = mk_req(1, 9, 7, 0);
        vecs[3].req[3] = mk_req(1, 2, 9, 0);
        vecs[3].pop = 4'b1100; vecs[3].base = 6'd20;
        vecs[3].exp[1] = mk_out(1, 0, 0, 0, 9);
        vecs[3].exp[2] = mk_out(1, 20, 9, 12, 0);
        vecs[3].exp[3] = mk_out(1, 21, 2, 20, 0);

        reset      = 1'b1;
        in_packet  = '0;
        free_cnt   = 7'd4;
        pop_packet = '0;
        pending    = '0;
        out_ready  = 1'b1;
        squash     = 1'b0;
        hold_prn   = 1'b0;
        next_prn   = '0;
        for (int i = 0; i < REG_SZ; i++) rrat_map[i] = PRN'(i);

        #12;
        chk("reset out_packet", 32'(out_packet[0] | out_packet[1] | out_packet[2] | out_packet[3]), 32'd0);
        chk("reset pop_en", 32'(pop_en), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int k = 0; k < 4; k++) run_vec(k);

        // free-list occupancy gate
        free_cnt     = 7'd3;
        in_packet[0] = mk_req(1, 10, 0, 0);
        #1;
        chk("free_cnt=N-1 in_ready", 32'(in_ready), 32'd0);
        chk("free_cnt=N-1 pop_en", 32'(pop_en), 32'd0);
        in_packet = '0;
        free_cnt  = 7'd64;
        #1;
        chk("free_cnt=64 in_ready", 32'(in_ready), 32'd1);
        free_cnt = 7'd4;
        $display("free_cnt gate sequence done");

        // downstream stall with PRNs arriving while held
        out_ready    = 1'b0;
        in_packet[0] = mk_req(1, 3, 1, 0);
        next_prn     = 6'd30;
        step();
        in_packet = '0;
        step();
        chk("stall G1 out", 32'(out_packet[0]), 32'(mk_out(1, 30, 3, 40, 0)));
        in_packet[0] = mk_req(1, 4, 3, 0);
        next_prn     = 6'd31;
        #1;
        chk("stall G2 accept", 32'(in_ready), 32'd1);
        step();
        in_packet = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall c%0d in_ready", c), 32'(in_ready), 32'd0);
            chk($sformatf("stall c%0d out held", c), 32'(out_packet[0]), 32'(mk_out(1, 30, 3, 40, 0)));
            step();
        end
        out_ready = 1'b1;
        step();
        chk("stall G2 out", 32'(out_packet[0]), 32'(mk_out(1, 31, 4, 30, 0)));
        step();
        chk("stall G2 once", 32'(out_packet[0]), 32'd0);
        $display("stall sequence done");

        // S1 waits for a late PRN
        hold_prn     = 1'b1;
        in_packet[0] = mk_req(1, 11, 4, 0);
        in_packet[1] = mk_req(1, 12, 11, 0);
        next_prn     = 6'd50;
        step();
        in_packet = '0;
        step();
        step();
        #1;
        chk("late prn no out", 32'(out_packet[0] | out_packet[1]), 32'd0);
        chk("late prn in_ready", 32'(in_ready), 32'd0);
        hold_prn = 1'b0;
        for (int i = 0; i < N; i++) pop_packet[i] = pending[i];
        step();
        chk("late prn slot0", 32'(out_packet[0]), 32'(mk_out(1, 50, 11, 31, 0)));
        chk("late prn slot1", 32'(out_packet[1]), 32'(mk_out(1, 51, 12, 50, 0)));
        step();
        $display("late PRN sequence done");

        // squash with S1 and OUT both occupied
        out_ready    = 1'b0;
        in_packet[0] = mk_req(1, 6, 0, 0);
        next_prn     = 6'd35;
        step();
        in_packet = '0;
        step();
        in_packet[0] = mk_req(1, 3, 0, 0);
        next_prn     = 6'd36;
        step();
        in_packet[0] = mk_req(1, 13, 0, 0);
        rrat_map[3]  = 6'd17;
        squash       = 1'b1;
        #1;
        chk("squash in_ready", 32'(in_ready), 32'd0);
        chk("squash pop_en", 32'(pop_en), 32'd0);
        step();
        #1;
        chk("squash out cleared", 32'(out_packet[0]), 32'd0);
        chk("squash idle in_ready", 32'(in_ready), 32'd0);
        chk("squash idle pop_en", 32'(pop_en), 32'd0);
        step();
        squash       = 1'b0;
        out_ready    = 1'b1;
        in_packet[0] = mk_req(1, 8, 3, 4);
        in_packet[1] = mk_req(1, 0, 6, 12);
        next_prn     = 6'd45;
        step();
        in_packet = '0;
        step();
        chk("post-squash slot0", 32'(out_packet[0]), 32'(mk_out(1, 45, 8, 17, 4)));
        chk("post-squash slot1", 32'(out_packet[1]), 32'(mk_out(1, 0, 0, 6, 12)));
        step();
        $display("squash sequence done");

        // asynchronous reset mid-operation
        in_packet[0] = mk_req(1, 1, 0, 0);
        next_prn     = 6'd60;
        step();
        in_packet = '0;
        step();
        chk("pre-reset out", 32'(out_packet[0]), 32'(mk_out(1, 60, 1, 0, 0)));
        #2;
        reset = 1'b1;
        #1;
        chk("async reset out", 32'(out_packet[0]), 32'd0);
        pending    = '0;
        pop_packet = '0;
        @(posedge clock);
        #1;
        reset        = 1'b0;
        in_packet[0] = mk_req(1, 2, 1, 5);
        next_prn     = 6'd61;
        step();
        in_packet = '0;
        step();
        chk("post-reset table", 32'(out_packet[0]), 32'(mk_out(1, 61, 2, 1, 5)));
        step();
        $display("async reset sequence done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
